mem_port_arbiter: RTL

Two-requester front end for the single-port `raw_memory` RAM, sitting directly upstream of it. It arbitrates between the instruction-fetch port (read-only) and the data port (read/write), and drives the RAM address, write-data and write-enable lines. It also accounts for the RAM's one-cycle registered-read latency and returns read data on the port that issued the read, holding it stable until that port's next read completes.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_grant.sv | 37 +++
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the mem_port_arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int OWNER_W = 2;

    typedef enum logic [OWNER_W-1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } rd_owner_t;

    // Round-robin pointer values: which port wins the next conflict.
    localparam logic RR_FETCH = 1'b0;
    localparam logic RR_DATA  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_grant
// Description : Combinational two-port grant logic; on a conflict the port
//               named by i_rr_ptr wins. No grants while reset is high.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic reset,
    input  logic i_fetch_req,
    input  logic i_data_req,
    input  logic i_rr_ptr,
    output logic o_fetch_gnt,
    output logic o_data_gnt
);

    always_comb begin
        o_fetch_gnt = 1'b0;
        o_data_gnt  = 1'b0;
        if (!reset) begin
            if (i_fetch_req && i_data_req) begin
                if (i_rr_ptr == RR_FETCH) begin
                    o_fetch_gnt = 1'b1;
                end else begin
                    o_data_gnt = 1'b1;
                end
            end else begin
                o_fetch_gnt = i_fetch_req;
                o_data_gnt  = i_data_req;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Fetch/data front end for a single-port RAM with one-cycle
//               registered read. Define MEM_ARB_RR_EN for round-robin
//               arbitration; otherwise the data port has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    logic                  w_i_gnt;
    logic                  w_d_gnt;
    logic                  w_rr_ptr;
    rd_owner_t             r_rd_owner_q;
    rd_owner_t             w_rd_owner_d;
    logic                  r_i_rvalid_q;
    logic                  w_i_rvalid_d;
    logic                  r_d_rvalid_q;
    logic                  w_d_rvalid_d;
    logic [DATA_WIDTH-1:0] r_i_rdata_q;
    logic [DATA_WIDTH-1:0] w_i_rdata_d;
    logic [DATA_WIDTH-1:0] r_d_rdata_q;
    logic [DATA_WIDTH-1:0] w_d_rdata_d;

`ifdef MEM_ARB_RR_EN
    logic r_rr_ptr_q;
    logic w_rr_ptr_d;

    // Pointer only moves on cycles where both ports compete.
    always_comb begin
        w_rr_ptr_d = r_rr_ptr_q;
        if (i_req && d_req) begin
            w_rr_ptr_d = ~r_rr_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr_q <= RR_FETCH;
        end else begin
            r_rr_ptr_q <= w_rr_ptr_d;
        end
    end

    assign w_rr_ptr = r_rr_ptr_q;
`else
    assign w_rr_ptr = RR_DATA;
`endif

    mem_arb_grant u_grant (
        .reset       (reset),
        .i_fetch_req (i_req),
        .i_data_req  (d_req),
        .i_rr_ptr    (w_rr_ptr),
        .o_fetch_gnt (w_i_gnt),
        .o_data_gnt  (w_d_gnt)
    );

    assign i_gnt    = w_i_gnt;
    assign d_gnt    = w_d_gnt;
    assign mem_addr = w_i_gnt ? i_addr : d_addr;
    assign mem_data = d_wdata;
    assign mem_we   = w_d_gnt & d_we;
    assign i_rvalid = r_i_rvalid_q;
    assign d_rvalid = r_d_rvalid_q;
    assign i_rdata  = r_i_rdata_q;
    assign d_rdata  = r_d_rdata_q;

    // mem_q is valid the cycle after a read grant; capture it for its owner.
    always_comb begin
        w_rd_owner_d = NONE;
        if (w_i_gnt) begin
            w_rd_owner_d = FETCH;
        end else if (w_d_gnt && !d_we) begin
            w_rd_owner_d = DATA;
        end
        w_i_rvalid_d = (r_rd_owner_q == FETCH);
        w_d_rvalid_d = (r_rd_owner_q == DATA);
        w_i_rdata_d  = (r_rd_owner_q == FETCH) ? mem_q : r_i_rdata_q;
        w_d_rdata_d  = (r_rd_owner_q == DATA)  ? mem_q : r_d_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_owner_q <= NONE;
            r_i_rvalid_q <= 1'b0;
            r_d_rvalid_q <= 1'b0;
            r_i_rdata_q  <= '0;
            r_d_rdata_q  <= '0;
        end else begin
            r_rd_owner_q <= w_rd_owner_d;
            r_i_rvalid_q <= w_i_rvalid_d;
            r_d_rvalid_q <= w_d_rvalid_d;
            r_i_rdata_q  <= w_i_rdata_d;
            r_d_rdata_q  <= w_d_rdata_d;
        end
    end

endmodule
`default_nettype wire
